// File: rtl/npc_sel_ctrl.sv
// Next-PC sequencer: owns the fetch PC and steers the 4:1 next-PC mux.
// Redirects raised during a stall are held in PEND until the stall releases.
module npc_sel_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc_req,
    input  logic        exc_clr,
    input  logic [31:0] npc_in,
    output logic [1:0]  pc_sel,
    output logic [31:0] pc,
    output logic        flush,
    output logic [31:0] epc,
    output logic        in_exc,
    output logic        pend
);

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_JMP = 2'b10;
    localparam logic [1:0] SEL_EXC = 2'b11;

    typedef enum logic {RUN, PEND} state_t;

    state_t      state, state_next;
    logic [1:0]  code;
    logic        exc_take;
    logic [1:0]  pend_sel, pend_sel_next;
    logic [31:0] pend_tgt, pend_tgt_next;
    logic [31:0] pc_next, epc_next;
    logic        in_exc_next;

    // The held target must be captured internally: the mux inputs may change
    // while the stall persists.
    function automatic logic [31:0] target_for(input logic [1:0] sel,
                                               input logic [31:0] br_t,
                                               input logic [31:0] jmp_t);
        case (sel)
            SEL_BR:  target_for = br_t;
            SEL_JMP: target_for = jmp_t;
            default: target_for = EXC_VEC;
        endcase
    endfunction

    assign exc_take = exc_req & ~in_exc;

    always_comb begin
        if (exc_take)      code = SEL_EXC;
        else if (jump)     code = SEL_JMP;
        else if (br_taken) code = SEL_BR;
        else               code = SEL_SEQ;
    end

    always_comb begin
        state_next    = state;
        pend_sel_next = pend_sel;
        pend_tgt_next = pend_tgt;
        pc_next       = pc;
        epc_next      = epc;
        in_exc_next   = in_exc & ~exc_clr;
        pc_sel        = SEL_SEQ;
        flush         = 1'b0;
        pend          = 1'b0;

        case (state)
            RUN: begin
                pc_sel = code;
                if (!stall) begin
                    pc_next = npc_in;
                    flush   = (code != SEL_SEQ);
                    if (code == SEL_EXC) begin
                        epc_next    = pc;
                        in_exc_next = 1'b1;
                    end
                end else if (code != SEL_SEQ) begin
                    pend_sel_next = code;
                    pend_tgt_next = target_for(code, br_target, jump_target);
                    state_next    = PEND;
                    if (code == SEL_EXC) begin
                        epc_next    = pc;
                        in_exc_next = 1'b1;
                    end
                end
            end
            PEND: begin
                pc_sel = pend_sel;
                pend   = 1'b1;
                if (stall) begin
                    // Only an unmasked exception may replace a held redirect.
                    if (exc_take) begin
                        pend_sel_next = SEL_EXC;
                        pend_tgt_next = EXC_VEC;
                        epc_next      = pc;
                        in_exc_next   = 1'b1;
                    end
                end else begin
                    flush      = 1'b1;
                    pc_next    = pend_tgt;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            pc     <= RESET_PC;
            epc    <= 32'h0;
            in_exc <= 1'b0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            epc    <= epc_next;
            in_exc <= in_exc_next;
        end
    end

    // Held redirect payload is only meaningful in PEND, so it carries no reset.
    always_ff @(posedge clk) begin
        pend_sel <= pend_sel_next;
        pend_tgt <= pend_tgt_next;
    end

endmodule

// File: tb/tb_npc_sel_ctrl.sv
// Scoreboard bench for npc_sel_ctrl: the driver queues per-cycle expectations,
// a monitor pops and compares them against the DUT outputs.
module tb_npc_sel_ctrl;

    localparam logic [31:0] EXC_VEC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        exc_req = 1'b0;
    logic        exc_clr = 1'b0;
    logic [31:0] npc_in;
    logic [1:0]  pc_sel;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] epc;
    logic        in_exc;
    logic        pend;

    npc_sel_ctrl dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .jump(jump), .jump_target(jump_target),
        .exc_req(exc_req), .exc_clr(exc_clr), .npc_in(npc_in),
        .pc_sel(pc_sel), .pc(pc), .flush(flush), .epc(epc),
        .in_exc(in_exc), .pend(pend)
    );

    // Datapath 4:1 mux with the pc+4 adder.
    always_comb begin
        case (pc_sel)
            2'b00:   npc_in = pc + 32'd4;
            2'b01:   npc_in = br_target;
            2'b10:   npc_in = jump_target;
            default: npc_in = EXC_VEC;
        endcase
    end

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [1:0]  sel;
        logic        flush;
        logic        pend;
        logic        in_exc;
        logic [31:0] epc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   vec_id = 0;

    task automatic step(input logic rst, input logic st,
                        input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt,
                        input logic ex, input logic clr,
                        input logic [31:0] e_pc, input logic [1:0] e_sel,
                        input logic e_fl, input logic e_pend,
                        input logic e_inexc, input logic [31:0] e_epc);
        exp_t e;
        @(negedge clk);
        rst_n = ~rst; stall = st; br_taken = br; br_target = bt;
        jump = j; jump_target = jt; exc_req = ex; exc_clr = clr;
        e.id = vec_id; e.pc = e_pc; e.sel = e_sel; e.flush = e_fl;
        e.pend = e_pend; e.in_exc = e_inexc; e.epc = e_epc;
        exp_q.push_back(e);
        vec_id++;
    endtask

    task automatic chk(input int id, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL vec%0d %s: got %h expected %h", id, name, act, req);
    endtask

    // Monitor: samples combinational outputs once the driver has settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.id, "pc", pc, e.pc);
                chk(e.id, "pc_sel", {30'h0, pc_sel}, {30'h0, e.sel});
                chk(e.id, "flush", {31'h0, flush}, {31'h0, e.flush});
                chk(e.id, "pend", {31'h0, pend}, {31'h0, e.pend});
                chk(e.id, "in_exc", {31'h0, in_exc}, {31'h0, e.in_exc});
                chk(e.id, "epc", epc, e.epc);
            end
        end
    end

    initial begin
        //    rst st br bt            j  jt            ex clr  pc            sel  fl pd ie epc
        step(1, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_3000, 2'b00, 0, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_3000, 2'b00, 0, 0, 0, 32'h0);
        // sequential fetch
        step(0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_3000, 2'b00, 0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_3004, 2'b00, 0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_3008, 2'b00, 0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_300C, 2'b00, 0, 0, 0, 32'h0);
        // branch, then jump beats branch
        step(0, 0, 1, 32'h0000_3100, 0, 32'h0,         0, 0, 32'h0000_3010, 2'b01, 1, 0, 0, 32'h0);
        step(0, 0, 1, 32'h0000_3100, 1, 32'h0000_3200, 0, 0, 32'h0000_3100, 2'b10, 1, 0, 0, 32'h0);
        // stalled branch held in PEND; jump during PEND ignored
        step(0, 1, 1, 32'h0000_3400, 0, 32'h0,         0, 0, 32'h0000_3200, 2'b01, 0, 0, 0, 32'h0);
        step(0, 1, 0, 32'h0,         1, 32'h0000_3900, 0, 0, 32'h0000_3200, 2'b01, 0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_3200, 2'b01, 0, 1, 0, 32'h0);
        step(0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_3200, 2'b01, 1, 1, 0, 32'h0);
        // jump back to 3008
        step(0, 0, 0, 32'h0,         1, 32'h0000_3008, 0, 0, 32'h0000_3400, 2'b10, 1, 0, 0, 32'h0);
        // exception entry, masked second request, exc_clr, re-entry
        step(0, 0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h0000_3008, 2'b11, 1, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h0000_4180, 2'b00, 0, 0, 1, 32'h0000_3008);
        step(0, 0, 0, 32'h0,         0, 32'h0,         1, 1, 32'h0000_4184, 2'b00, 0, 0, 1, 32'h0000_3008);
        step(0, 0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h0000_4188, 2'b11, 1, 0, 0, 32'h0000_3008);
        step(0, 0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_4180, 2'b00, 0, 0, 1, 32'h0000_4188);
        // PEND(01) overwritten by exception; later branch cannot displace it
        step(0, 1, 1, 32'h0000_3500, 0, 32'h0,         0, 0, 32'h0000_4184, 2'b01, 0, 0, 0, 32'h0000_4188);
        step(0, 1, 0, 32'h0,         0, 32'h0,         1, 0, 32'h0000_4184, 2'b01, 0, 1, 0, 32'h0000_4188);
        step(0, 1, 1, 32'h0000_3600, 0, 32'h0,         0, 0, 32'h0000_4184, 2'b11, 0, 1, 1, 32'h0000_4184);
        step(0, 0, 1, 32'h0000_3600, 0, 32'h0,         0, 0, 32'h0000_4184, 2'b11, 1, 1, 1, 32'h0000_4184);
        step(0, 0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_4180, 2'b00, 0, 0, 1, 32'h0000_4184);
        // reset while in PEND
        step(0, 1, 1, 32'h0000_3700, 0, 32'h0,         0, 0, 32'h0000_4184, 2'b01, 0, 0, 0, 32'h0000_4184);
        step(0, 1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_4184, 2'b01, 0, 1, 0, 32'h0000_4184);
        step(1, 1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_3000, 2'b00, 0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_3000, 2'b00, 0, 0, 0, 32'h0);
        // pc+4 wraps through zero
        step(0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 0, 32'h0000_3004, 2'b10, 1, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'hFFFF_FFFC, 2'b00, 0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_0000, 2'b00, 0, 0, 0, 32'h0);

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
        #3;
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
